// File: rtl/note_store_player_if.sv
// Signal bundle between the record/playback sequencer, the note store/player
// and the audio side.
interface note_store_player_if #(
    parameter int NOTE_W = 3
);
    logic              ld_note;
    logic              ld_play;
    logic [3:0]        note_counter;
    logic [NOTE_W-1:0] note_sel;
    logic              tone_out;
    logic [NOTE_W-1:0] playing_note;
    logic [4:0]        notes_stored;
    logic              mem_full;

    // Sequencer / stimulus side
    modport master (
        output ld_note, ld_play, note_counter, note_sel,
        input  tone_out, playing_note, notes_stored, mem_full
    );

    // Note store / player side
    modport slave (
        input  ld_note, ld_play, note_counter, note_sel,
        output tone_out, playing_note, notes_stored, mem_full
    );
endinterface

// File: rtl/note_store_player.sv
// Note store and player: records up to 16 note codes (one per ld_note pulse),
// selects the note to sound (live audition, playback from memory, or rest)
// and generates a square wave whose half period comes from a fixed table.
module note_store_player #(
    parameter int NOTE_W  = 3,
    parameter int CNT_W   = 17,
    parameter int SIM_DIV = 0
) (
    input  logic              clk,
    input  logic              reset,
    note_store_player_if.slave bus
);

    typedef enum logic [1:0] {
        ST_REST,
        ST_RELOAD,
        ST_RUN
    } tone_state_t;

    // Half period in 50 MHz clocks for each note code; code 0 (rest) has none.
    function automatic logic [CNT_W-1:0] half_period(input logic [NOTE_W-1:0] code);
        logic [31:0] hp;
        case (code)
            1:       hp = 32'd95556;
            2:       hp = 32'd85131;
            3:       hp = 32'd75843;
            4:       hp = 32'd71586;
            5:       hp = 32'd63776;
            6:       hp = 32'd56818;
            7:       hp = 32'd50619;
            default: hp = 32'd0;
        endcase
        return CNT_W'(hp >> SIM_DIV);
    endfunction

    logic [NOTE_W-1:0] mem_q [16];
    logic [4:0]        wr_ptr_q;
    logic              ld_note_dly_q;
    logic              wr_en;

    logic [NOTE_W-1:0] playing_note_q, playing_note_d;
    tone_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tone_q, tone_d;
    logic [CNT_W-1:0]  reload_val;

    // One write per ld_note rising edge; a full store ignores further pulses.
    assign wr_en = bus.ld_note & ~ld_note_dly_q & ~wr_ptr_q[4];

    // Write path: edge detector, write pointer and the 16-entry note memory.
    // The memory is cleared on reset so unwritten entries read back as rest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_note_dly_q <= 1'b0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ld_note_dly_q <= bus.ld_note;
            if (wr_en) begin
                mem_q[wr_ptr_q[3:0]] <= bus.note_sel;
                wr_ptr_q             <= wr_ptr_q + 5'd1;
            end
        end
    end

    // Note select and tone-state decode: audition beats playback beats rest;
    // any change of the sounded note forces a reload so the phase restarts low.
    always_comb begin
        playing_note_d = '0;
        if (bus.ld_note) begin
            playing_note_d = bus.note_sel;
        end else if (bus.ld_play) begin
            playing_note_d = mem_q[bus.note_counter];
        end

        state_d = ST_RUN;
        if (playing_note_d == '0) begin
            state_d = ST_REST;
        end else if (playing_note_d != playing_note_q) begin
            state_d = ST_RELOAD;
        end
    end

    assign reload_val = half_period(playing_note_q) - CNT_W'(1);

    // Half-period counter and square-wave output for the current tone state.
    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        case (state_q)
            ST_REST: begin
                cnt_d  = '0;
                tone_d = 1'b0;
            end
            ST_RELOAD: begin
                cnt_d  = reload_val;
                tone_d = 1'b0;
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    cnt_d  = reload_val;
                    tone_d = ~tone_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d  = '0;
                tone_d = 1'b0;
            end
        endcase
    end

    // Playback registers: selected note, tone state, counter and output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            playing_note_q <= '0;
            state_q        <= ST_REST;
            cnt_q          <= '0;
            tone_q         <= 1'b0;
        end else begin
            playing_note_q <= playing_note_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tone_q         <= tone_d;
        end
    end

    assign bus.tone_out     = tone_q;
    assign bus.playing_note = playing_note_q;
    assign bus.notes_stored = wr_ptr_q;
    assign bus.mem_full     = wr_ptr_q[4];

endmodule

// File: tb/tb_note_store_player.sv
// Directed bench for note_store_player: expected values are queued when a
// stimulus step is driven and popped when the matching output is sampled.
module tb_note_store_player;

    localparam int NOTE_W  = 3;
    localparam int CNT_W   = 17;
    localparam int SIM_DIV = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    note_store_player_if #(.NOTE_W(NOTE_W)) bus ();

    note_store_player #(
        .NOTE_W (NOTE_W),
        .CNT_W  (CNT_W),
        .SIM_DIV(SIM_DIV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int hp(input int code);
        int v;
        case (code)
            1: v = 95556;
            2: v = 85131;
            3: v = 75843;
            4: v = 71586;
            5: v = 63776;
            6: v = 56818;
            7: v = 50619;
            default: v = 0;
        endcase
        return v >> SIM_DIV;
    endfunction

    task automatic push_exp(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check_pop(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0d expected <none>", obs);
            return;
        end
        e = sb_q.pop_front();
        checks++;
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
        end
        $display("check %-14s observed %0d expected %0d", e.tag, obs, e.val);
    endtask

    task automatic pulse(input logic [NOTE_W-1:0] sel, input int len);
        @(negedge clk);
        bus.ld_note  = 1'b1;
        bus.note_sel = sel;
        repeat (len) @(negedge clk);
        bus.ld_note = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_mem(input int idx, input int expv, input string tag);
        @(negedge clk);
        bus.ld_play      = 1'b1;
        bus.note_counter = 4'(idx);
        push_exp(tag, expv);
        @(negedge clk);
        check_pop(32'(bus.playing_note));
    endtask

    // Counts negedges until tone_out reaches lvl; bounded so a dead tone
    // shows up as a wrong count instead of a hang.
    task automatic wait_level(input logic lvl, output int n);
        n = 0;
        while (bus.tone_out !== lvl && n <= 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int highs;

        bus.ld_note      = 1'b0;
        bus.ld_play      = 1'b0;
        bus.note_counter = '0;
        bus.note_sel     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        push_exp("rst_tone", 0);    check_pop(32'(bus.tone_out));
        push_exp("rst_note", 0);    check_pop(32'(bus.playing_note));
        push_exp("rst_stored", 0);  check_pop(32'(bus.notes_stored));
        push_exp("rst_full", 0);    check_pop(32'(bus.mem_full));
        @(negedge clk);
        reset = 1'b1;

        // Three pulses 1, 6, 3 with a live-audition check on the first
        @(negedge clk);
        bus.ld_note  = 1'b1;
        bus.note_sel = 3'd1;
        push_exp("audition", 1);
        @(negedge clk);
        check_pop(32'(bus.playing_note));
        repeat (4) @(negedge clk);
        bus.ld_note = 1'b0;
        @(negedge clk);
        pulse(3'd6, 5);
        pulse(3'd3, 5);
        push_exp("stored_3", 3);    check_pop(32'(bus.notes_stored));
        push_exp("full_at_3", 0);   check_pop(32'(bus.mem_full));
        read_mem(0, 1, "mem0");
        read_mem(1, 6, "mem1");
        read_mem(2, 3, "mem2");

        // Back to rest, then play index 1 (note 6) and time the waveform
        @(negedge clk);
        bus.ld_play = 1'b0;
        repeat (3) @(negedge clk);
        bus.ld_play      = 1'b1;
        bus.note_counter = 4'd1;
        push_exp("play_latency", 6);
        @(negedge clk);
        check_pop(32'(bus.playing_note));
        push_exp("tone6_rise", hp(6) + 1);
        wait_level(1'b1, n);
        check_pop(32'(n));
        push_exp("tone6_high", hp(6));
        wait_level(1'b0, n);
        check_pop(32'(n));
        push_exp("tone6_low", hp(6));
        wait_level(1'b1, n);
        check_pop(32'(n));

        // Index beyond what was stored plays rest
        @(negedge clk);
        bus.note_counter = 4'd5;
        push_exp("unwritten_idx", 0);
        @(negedge clk);
        check_pop(32'(bus.playing_note));
        repeat (2) @(negedge clk);
        highs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.tone_out !== 1'b0) highs++;
        end
        push_exp("rest_silent", 0);
        check_pop(32'(highs));
        bus.ld_play = 1'b0;

        // A long pulse writes exactly once
        pulse(3'd5, 40);
        push_exp("long_pulse", 4);  check_pop(32'(bus.notes_stored));

        // ld_note beats ld_play, and the write still happens
        @(negedge clk);
        bus.ld_play      = 1'b1;
        bus.note_counter = 4'd0;
        push_exp("play_mem0", 1);
        @(negedge clk);
        check_pop(32'(bus.playing_note));
        bus.ld_note  = 1'b1;
        bus.note_sel = 3'd4;
        push_exp("both_high", 4);
        @(negedge clk);
        check_pop(32'(bus.playing_note));
        repeat (3) @(negedge clk);
        bus.ld_note = 1'b0;
        bus.ld_play = 1'b0;
        @(negedge clk);
        push_exp("both_write", 5); check_pop(32'(bus.notes_stored));
        read_mem(4, 4, "mem4");
        @(negedge clk);
        bus.ld_play = 1'b0;
        repeat (2) @(negedge clk);

        // Audition note 4, then switch to 7 while tone_out is high
        bus.ld_note  = 1'b1;
        bus.note_sel = 3'd4;
        push_exp("tone4_rise", hp(4) + 2);
        wait_level(1'b1, n);
        check_pop(32'(n));
        bus.note_sel = 3'd7;
        push_exp("switch_note", 7);
        @(negedge clk);
        check_pop(32'(bus.playing_note));
        push_exp("switch_low", 0);
        @(negedge clk);
        check_pop(32'(bus.tone_out));
        push_exp("tone7_rise", hp(7));
        wait_level(1'b1, n);
        check_pop(32'(n));

        // Asynchronous reset in the middle of a high tone phase
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        push_exp("arst_tone", 0);   check_pop(32'(bus.tone_out));
        push_exp("arst_note", 0);   check_pop(32'(bus.playing_note));
        push_exp("arst_stored", 0); check_pop(32'(bus.notes_stored));
        push_exp("arst_full", 0);   check_pop(32'(bus.mem_full));
        bus.ld_note = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        read_mem(0, 0, "arst_mem0");
        read_mem(4, 0, "arst_mem4");
        @(negedge clk);
        bus.ld_play = 1'b0;

        // ld_note high at reset release counts as the first write of note 2
        @(negedge clk);
        reset        = 1'b0;
        bus.ld_note  = 1'b1;
        bus.note_sel = 3'd2;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        bus.ld_note = 1'b0;
        @(negedge clk);
        push_exp("rel_write", 1);   check_pop(32'(bus.notes_stored));

        // Fill to the boundary, then one extra pulse
        for (int i = 0; i < 14; i++) pulse(3'd2, 3);
        push_exp("stored_15", 15);  check_pop(32'(bus.notes_stored));
        push_exp("full_at_15", 0);  check_pop(32'(bus.mem_full));
        pulse(3'd2, 3);
        push_exp("stored_16", 16);  check_pop(32'(bus.notes_stored));
        push_exp("full_at_16", 1);  check_pop(32'(bus.mem_full));
        pulse(3'd5, 3);
        push_exp("stored_17", 16);  check_pop(32'(bus.notes_stored));
        push_exp("full_at_17", 1);  check_pop(32'(bus.mem_full));
        read_mem(0, 2, "full_mem0");
        read_mem(15, 2, "full_mem15");
        @(negedge clk);
        bus.ld_play = 1'b0;

        if (sb_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_left: observed %0d expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
